uart_tx_feeder: RTL and testbench

- Buffers bytes from a host-side valid/ready stream and feeds them one at a time into the UART transmitter through its enable/i_data/o_busy interface.
- Sits directly upstream of the transmitter, in the transmitter clock domain.
- Decouples bursty producers from the slow serial line, detects a transmitter that never acknowledges a launch, and reports buffer occupancy.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_feeder_if.sv | 29 ++
 rtl/uart_sync_fifo.sv | 62 ++++++
 rtl/uart_tx_feeder.sv | 113 +++++++++++
 tb/tb_uart_tx_feeder.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks: default widths,
// feeder state encoding and the occupancy-counter width helper.
package uart_pkg;

    localparam int DATA_WIDTH_DEFAULT = 8;
    localparam int FIFO_DEPTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        SENDING = 2'd2
    } feeder_state_e;

    // An occupancy counter must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int COUNT_WIDTH_DEFAULT = count_width(FIFO_DEPTH_DEFAULT);

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Host stream plus transmitter handshake of the UART transmit feeder.
// slave is the feeder's view; master is the host/transmitter view.
interface uart_tx_feeder_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
);
    logic                               s_valid;
    logic [DATA_WIDTH-1:0]              s_data;
    logic                               s_ready;
    logic                               flush;
    logic                               tx_enable;
    logic [DATA_WIDTH-1:0]              tx_data;
    logic                               tx_busy;
    logic                               tx_done;
    logic                               err_timeout;
    logic [count_width(FIFO_DEPTH)-1:0] fifo_count;

    modport slave (
        input  s_valid, s_data, flush, tx_busy,
        output s_ready, tx_enable, tx_data, tx_done, err_timeout, fifo_count
    );

    modport master (
        output s_valid, s_data, flush, tx_busy,
        input  s_ready, tx_enable, tx_data, tx_done, err_timeout, fifo_count
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with push/pop/flush, full/empty and occupancy count.
// Head entry is presented combinationally on rd_data.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int DEPTH      = FIFO_DEPTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         rd_data,
    input  logic                          flush,
    output logic                          full,
    output logic                          empty,
    output logic [count_width(DEPTH)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // No bypass: a full FIFO refuses a push even when a pop happens alongside.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately left out of reset; only pointers and count
    // define validity, and a reset-free array maps onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers host bytes and launches them one at a time into the UART
// transmitter, watching for a launch that the transmitter never acknowledges.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEFAULT,
    parameter int ACK_TIMEOUT = 1023
) (
    input logic             clk,
    input logic             reset,
    uart_tx_feeder_if.slave bus
);
    localparam int CW = count_width(FIFO_DEPTH);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    feeder_state_e         state_q, state_d;
    logic [TW-1:0]         cnt_q, cnt_d;
    logic                  tx_enable_q, tx_enable_d;
    logic                  tx_done_q, tx_done_d;
    logic                  err_q;
    logic                  timeout_hit;
    logic                  pop;
    logic                  push;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;

    assign bus.s_ready     = !fifo_full && reset;
    assign push            = bus.s_valid && bus.s_ready;
    assign bus.tx_enable   = tx_enable_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_done     = tx_done_q;
    assign bus.err_timeout = err_q;
    assign bus.fifo_count  = fifo_count;

    uart_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (bus.s_data),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .flush   (bus.flush),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tx_enable_q <= 1'b0;
            tx_done_q   <= 1'b0;
            err_q       <= 1'b0;
            tx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tx_enable_q <= tx_enable_d;
            tx_done_q   <= tx_done_d;
            if (timeout_hit) err_q     <= 1'b1;
            if (pop)         tx_data_q <= fifo_rd_data;
        end
    end

    // NOTE: every output of this block is defaulted first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tx_enable_d = 1'b0;
        tx_done_d   = 1'b0;
        timeout_hit = 1'b0;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !bus.tx_busy && !bus.flush) begin
                    pop         = 1'b1;
                    tx_enable_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = LAUNCH;
                end
            end
            // Enable is held because the transmitter only samples it on its baud tick.
            LAUNCH: begin
                if (bus.tx_busy) begin
                    state_d = SENDING;
                end else if (cnt_q == TW'(ACK_TIMEOUT)) begin
                    timeout_hit = 1'b1;
                    state_d     = IDLE;
                end else begin
                    tx_enable_d = 1'b1;
                    cnt_d       = cnt_q + 1'b1;
                end
            end
            SENDING: begin
                if (!bus.tx_busy) begin
                    tx_done_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: a host driver, a simple
// transmitter model reacting to tx_enable, directed sequences and a random run.
module tb_uart_tx_feeder;
    import uart_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int ACK   = 7;
    localparam int CW    = count_width(DEPTH);

    typedef struct {
        logic          valid;
        logic [DW-1:0] data;
        logic          exp_ready;
        logic [CW-1:0] exp_count;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    uart_tx_feeder_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

    uart_tx_feeder #(
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (DEPTH),
        .ACK_TIMEOUT (ACK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] launched [$];
    int            done_cnt;
    logic          prev_en;
    logic          rose;

    bit model_en;
    bit rand_model;
    int en_seen;
    int busy_left;
    int busy_delay;
    int busy_len;

    vec_t vec [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transmitter model: busy rises after enable has been seen busy_delay cycles.
    task automatic model_step();
        if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) bus.tx_busy = 1'b0;
        end else if (bus.tx_enable) begin
            en_seen++;
            if (en_seen >= busy_delay) begin
                bus.tx_busy = 1'b1;
                busy_left   = busy_len;
                en_seen     = 0;
                if (rand_model) begin
                    busy_delay = $urandom_range(1, 4);
                    busy_len   = $urandom_range(1, 6);
                end
            end
        end else begin
            en_seen = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rose = bus.tx_enable && !prev_en;
        if (rose) launched.push_back(bus.tx_data);
        if (bus.tx_done) done_cnt++;
        prev_en = bus.tx_enable;
        if (model_en) model_step();
    endtask

    task automatic model_off();
        model_en    = 1'b0;
        rand_model  = 1'b0;
        en_seen     = 0;
        busy_left   = 0;
        bus.tx_busy = 1'b0;
    endtask

    task automatic model_on(input int delay, input int len);
        en_seen    = 0;
        busy_left  = 0;
        busy_delay = delay;
        busy_len   = len;
        model_en   = 1'b1;
    endtask

    task automatic clear_log();
        launched.delete();
        done_cnt = 0;
    endtask

    task automatic push_byte(input logic [DW-1:0] d);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        tick();
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget, input string name);
        int c = 0;
        while (done_cnt < n && c < budget) begin
            tick();
            c++;
        end
        check(name, done_cnt, n);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int en_cnt, first_en, fall, done_at, sent, occ, bad;
        logic data_ok, prev_busy, acc;
        logic [DW-1:0] bytes [40];

        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.flush   = 1'b0;
        model_off();
        clear_log();
        prev_en = 1'b0;

        // ---- reset state ----
        #12;
        check("rst_s_ready", bus.s_ready, 0);
        check("rst_tx_enable", bus.tx_enable, 0);
        check("rst_count", bus.fifo_count, 0);
        check("rst_err", bus.err_timeout, 0);
        check("rst_done", bus.tx_done, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("rel_s_ready", bus.s_ready, 1);

        // ---- single byte, busy 3 cycles after enable for 20 cycles ----
        clear_log();
        model_on(3, 20);
        push_byte(8'hA5);
        check("single_lat_count", bus.fifo_count, 1);
        check("single_lat_en", bus.tx_enable, 0);
        first_en = -1; en_cnt = 0; data_ok = 1'b1; fall = -1; done_at = -1;
        prev_busy = bus.tx_busy;
        for (int c = 1; c <= 40; c++) begin
            if (bus.tx_enable) begin
                en_cnt++;
                if (first_en < 0) first_en = c;
                if (bus.tx_data !== 8'hA5) data_ok = 1'b0;
            end
            if (prev_busy && !bus.tx_busy && fall < 0) fall = c;
            prev_busy = bus.tx_busy;
            if (bus.tx_done && done_at < 0) done_at = c;
            tick();
        end
        check("single_first_en", first_en, 2);
        check("single_en_cycles", en_cnt, 3);
        check("single_data", data_ok, 1);
        check("single_done_cnt", done_cnt, 1);
        check("single_done_at", done_at, fall + 1);
        check("single_count", bus.fifo_count, 0);
        check("single_launch_n", launched.size(), 1);
        if (launched.size() == 1) check("single_launch_data", launched[0], 8'hA5);

        // ---- fill to full with transmitter busy (table driven) ----
        model_off();
        bus.tx_busy = 1'b1;
        clear_log();
        for (int i = 0; i < 17; i++) begin
            vec[i].valid     = 1'b1;
            vec[i].data      = DW'(i);
            vec[i].exp_ready = (i < DEPTH);
            vec[i].exp_count = CW'((i + 1 < DEPTH) ? i + 1 : DEPTH);
        end
        for (int i = 0; i < 17; i++) begin
            bus.s_valid = vec[i].valid;
            bus.s_data  = vec[i].data;
            check($sformatf("fill_ready_%0d", i), bus.s_ready, vec[i].exp_ready);
            tick();
            check($sformatf("fill_count_%0d", i), bus.fifo_count, vec[i].exp_count);
        end
        bus.s_valid = 1'b0;
        check("fill_no_launch", launched.size(), 0);
        bus.tx_busy = 1'b0;
        model_on(2, 3);
        wait_done(16, 1000, "drain_done");
        check("drain_n", launched.size(), 16);
        for (int i = 0; i < launched.size() && i < 16; i++)
            check($sformatf("drain_order_%0d", i), launched[i], i);
        check("drain_count", bus.fifo_count, 0);

        // ---- timeout: transmitter never acknowledges ----
        model_off();
        clear_log();
        push_byte(8'h3C);
        en_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.tx_enable) en_cnt++;
        end
        check("to_en_cycles", en_cnt, ACK + 1);
        check("to_err", bus.err_timeout, 1);
        check("to_no_done", done_cnt, 0);
        check("to_count", bus.fifo_count, 0);
        for (int c = 0; c < 10; c++) tick();
        check("to_err_sticky", bus.err_timeout, 1);
        model_on(2, 4);
        push_byte(8'h5A);
        wait_done(1, 100, "to_next_done");
        check("to_next_n", launched.size(), 2);
        if (launched.size() == 2) check("to_next_data", launched[1], 8'h5A);
        check("to_err_still", bus.err_timeout, 1);

        // ---- flush with one byte in flight ----
        model_off();
        bus.tx_busy = 1'b1;
        clear_log();
        for (int i = 0; i < 5; i++) push_byte(DW'(8'h10 + i));
        check("fl_count5", bus.fifo_count, 5);
        bus.tx_busy = 1'b0;
        tick();
        check("fl_launch_en", bus.tx_enable, 1);
        bus.tx_busy = 1'b1;
        tick();
        check("fl_sending_en", bus.tx_enable, 0);
        check("fl_count4", bus.fifo_count, 4);
        bus.flush   = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hEE;
        tick();
        bus.flush   = 1'b0;
        bus.s_valid = 1'b0;
        check("fl_count0", bus.fifo_count, 0);
        for (int c = 0; c < 3; c++) tick();
        bus.tx_busy = 1'b0;
        for (int c = 0; c < 12; c++) tick();
        check("fl_done", done_cnt, 1);
        check("fl_launch_n", launched.size(), 1);
        if (launched.size() == 1) check("fl_launch_data", launched[0], 8'h10);
        check("fl_count_end", bus.fifo_count, 0);

        // ---- simultaneous push and pop at count 1 ----
        model_off();
        bus.tx_busy = 1'b1;
        clear_log();
        push_byte(8'h21);
        check("pp_count1", bus.fifo_count, 1);
        bus.tx_busy = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h22;
        tick();
        bus.s_valid = 1'b0;
        check("pp_count_same", bus.fifo_count, 1);
        check("pp_en", bus.tx_enable, 1);
        check("pp_data", bus.tx_data, 8'h21);
        model_on(2, 3);
        wait_done(2, 200, "pp_done");
        check("pp_n", launched.size(), 2);
        if (launched.size() == 2) begin
            check("pp_order0", launched[0], 8'h21);
            check("pp_order1", launched[1], 8'h22);
        end

        // ---- random traffic through pointer wrap against a scoreboard ----
        model_on($urandom_range(1, 4), $urandom_range(1, 6));
        rand_model = 1'b1;
        clear_log();
        for (int i = 0; i < 40; i++) bytes[i] = DW'($urandom);
        sent = 0; occ = 0; bad = 0;
        for (int c = 0; c < 3000 && done_cnt < 40; c++) begin
            if (!bus.s_valid && sent < 40 && $urandom_range(0, 1) == 1) begin
                bus.s_valid = 1'b1;
                bus.s_data  = bytes[sent];
            end
            acc = bus.s_valid && bus.s_ready;
            tick();
            if (acc) begin
                sent++;
                occ++;
                bus.s_valid = 1'b0;
            end
            if (rose) occ--;
            if (int'(bus.fifo_count) != occ) bad++;
        end
        bus.s_valid = 1'b0;
        check("rand_done", done_cnt, 40);
        check("rand_occupancy", bad, 0);
        check("rand_n", launched.size(), 40);
        for (int i = 0; i < launched.size() && i < 40; i++)
            check($sformatf("rand_byte_%0d", i), launched[i], bytes[i]);
        check("rand_err", bus.err_timeout, 1);

        // ---- asynchronous reset while in LAUNCH ----
        model_off();
        clear_log();
        push_byte(8'h77);
        tick();
        check("ar_en_before", bus.tx_enable, 1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_en", bus.tx_enable, 0);
        check("ar_s_ready", bus.s_ready, 0);
        check("ar_count", bus.fifo_count, 0);
        check("ar_err", bus.err_timeout, 0);
        @(negedge clk);
        reset = 1'b1;
        prev_en = 1'b0;
        tick();
        check("ar_rel_ready", bus.s_ready, 1);
        check("ar_rel_err", bus.err_timeout, 0);
        check("ar_rel_en", bus.tx_enable, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
